// File: rtl/mips_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | mips_ctrl_pkg : shared encodings for the MIPS multi-cycle controller       |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_DECODE = 4'd2;
    localparam logic [3:0] ST_MEMADR = 4'd3;
    localparam logic [3:0] ST_MEMRD  = 4'd4;
    localparam logic [3:0] ST_MEMWB  = 4'd5;
    localparam logic [3:0] ST_MEMWR  = 4'd6;
    localparam logic [3:0] ST_EXEC   = 4'd7;
    localparam logic [3:0] ST_ALUWB  = 4'd8;
    localparam logic [3:0] ST_BRANCH = 4'd9;
    localparam logic [3:0] ST_JUMP   = 4'd10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_RT    = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/multicycle_control.sv
// +----------------------------------------------------------------------------+
// | multicycle_control : Moore sequencing FSM for the multi-cycle MIPS         |
// | datapath with memory-ready handshake and retired-instruction counter.     |
// | Optional feature macro: MC_JUMP_EN (adds the J instruction / JUMP state). |
// | Revision           : 1.0                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pcwrite,
    output logic             pcwritecond,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             irwrite,
    output logic             memtoreg,
    output logic             regdst,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       aluop,
    output logic [1:0]       pcsource,
    output logic             illegal_op,
    output logic [3:0]       state_dbg,
    output logic [CNT_W-1:0] instr_count
);

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [CNT_W-1:0] r_count;
    logic             w_retire;
    logic             w_legal;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_legal = (opcode == OP_RTYPE) || (opcode == OP_LW) ||
                  (opcode == OP_SW)    || (opcode == OP_BEQ);
`ifdef MC_JUMP_EN
        if (opcode == OP_J) begin
            w_legal = 1'b1;
        end
`endif
    end

    always_comb begin
        w_next = ST_FETCH;
        case (r_state)
            ST_IDLE:   w_next = ST_FETCH;
            ST_FETCH:  w_next = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     w_next = ST_EXEC;
                    OP_LW, OP_SW: w_next = ST_MEMADR;
                    OP_BEQ:       w_next = ST_BRANCH;
`ifdef MC_JUMP_EN
                    OP_J:         w_next = ST_JUMP;
`endif
                    default:      w_next = ST_FETCH;
                endcase
            end
            ST_MEMADR: w_next = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  w_next = mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:  w_next = ST_FETCH;
            ST_MEMWR:  w_next = mem_ready ? ST_FETCH : ST_MEMWR;
            ST_EXEC:   w_next = ST_ALUWB;
            ST_ALUWB:  w_next = ST_FETCH;
            ST_BRANCH: w_next = ST_FETCH;
            // JUMP (when built without the jump feature) and codes 11-15 recover here
            default:   w_next = ST_FETCH;
        endcase
    end

    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = ALUSRCB_RT;
        aluop       = ALUOP_ADD;
        pcsource    = PCSRC_ALU;
        illegal_op  = 1'b0;
        case (r_state)
            ST_FETCH: begin
                // IR and PC only load once memory actually returns the word
                memread  = 1'b1;
                alusrcb  = ALUSRCB_FOUR;
                irwrite  = mem_ready;
                pcwrite  = mem_ready;
            end
            ST_DECODE: begin
                alusrcb    = ALUSRCB_IMMSH;
                illegal_op = ~w_legal;
            end
            ST_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = ALUSRCB_IMM;
            end
            ST_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            ST_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            ST_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            ST_EXEC: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            ST_BRANCH: begin
                alusrca     = 1'b1;
                aluop       = ALUOP_SUB;
                pcwritecond = 1'b1;
                pcsource    = PCSRC_ALUOUT;
            end
`ifdef MC_JUMP_EN
            ST_JUMP: begin
                pcwrite  = 1'b1;
                pcsource = PCSRC_JUMP;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        w_retire = (r_state == ST_MEMWB) || (r_state == ST_ALUWB) ||
                   (r_state == ST_BRANCH) ||
                   ((r_state == ST_MEMWR) && mem_ready);
`ifdef MC_JUMP_EN
        if (r_state == ST_JUMP) begin
            w_retire = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_retire) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign state_dbg   = r_state;
    assign instr_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// +----------------------------------------------------------------------------+
// | tb_multicycle_control : scoreboard bench for multicycle_control            |
// | Revision              : 1.0                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_multicycle_control;

`ifdef MC_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       illegal;
    } ctrl_t;

    typedef struct {
        int    st;
        ctrl_t c;
        int    cnt;
    } exp_t;

    typedef struct {
        int st;
        bit rdy;
        bit useop;
    } step_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic       mem_ready = 1'b0;

    logic        a_pcwrite, a_pcwritecond, a_iord, a_memread, a_memwrite, a_irwrite;
    logic        a_memtoreg, a_regdst, a_regwrite, a_alusrca, a_illegal;
    logic [1:0]  a_alusrcb, a_aluop, a_pcsource;
    logic [3:0]  a_state;
    logic [15:0] a_count;

    logic        b_pcwrite, b_pcwritecond, b_iord, b_memread, b_memwrite, b_irwrite;
    logic        b_memtoreg, b_regdst, b_regwrite, b_alusrca, b_illegal;
    logic [1:0]  b_alusrcb, b_aluop, b_pcsource;
    logic [3:0]  b_state;
    logic [1:0]  b_count;

    multicycle_control #(.CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pcwrite(a_pcwrite), .pcwritecond(a_pcwritecond), .iord(a_iord),
        .memread(a_memread), .memwrite(a_memwrite), .irwrite(a_irwrite),
        .memtoreg(a_memtoreg), .regdst(a_regdst), .regwrite(a_regwrite),
        .alusrca(a_alusrca), .alusrcb(a_alusrcb), .aluop(a_aluop),
        .pcsource(a_pcsource), .illegal_op(a_illegal), .state_dbg(a_state),
        .instr_count(a_count)
    );

    // Narrow counter copy shares the stimulus to exercise wrap-around
    multicycle_control #(.CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pcwrite(b_pcwrite), .pcwritecond(b_pcwritecond), .iord(b_iord),
        .memread(b_memread), .memwrite(b_memwrite), .irwrite(b_irwrite),
        .memtoreg(b_memtoreg), .regdst(b_regdst), .regwrite(b_regwrite),
        .alusrca(b_alusrca), .alusrcb(b_alusrcb), .aluop(b_aluop),
        .pcsource(b_pcsource), .illegal_op(b_illegal), .state_dbg(b_state),
        .instr_count(b_count)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   model_cnt = 0;
    exp_t exp_q[$];

    function automatic bit is_legal(logic [5:0] op);
        return (op == 6'd0) || (op == 6'd35) || (op == 6'd43) || (op == 6'd4) ||
               (JUMP_EN && op == 6'd2);
    endfunction

    function automatic ctrl_t exp_ctrl(int st, logic [5:0] op, bit rdy);
        ctrl_t c = '0;
        case (st)
            1:  begin c.memread = 1; c.alusrcb = 2'b01; c.irwrite = rdy; c.pcwrite = rdy; end
            2:  begin c.alusrcb = 2'b11; c.illegal = !is_legal(op); end
            3:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
            4:  begin c.memread = 1; c.iord = 1; end
            5:  begin c.regwrite = 1; c.memtoreg = 1; end
            6:  begin c.memwrite = 1; c.iord = 1; end
            7:  begin c.alusrca = 1; c.aluop = 2'b10; end
            8:  begin c.regwrite = 1; c.regdst = 1; end
            9:  begin c.alusrca = 1; c.aluop = 2'b01; c.pcwritecond = 1; c.pcsource = 2'b01; end
            10: if (JUMP_EN) begin c.pcwrite = 1; c.pcsource = 2'b10; end
            default: ;
        endcase
        return c;
    endfunction

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; its expected response goes to the scoreboard
    task automatic drive(bit rn, logic [5:0] op, bit rdy, int st);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = rn;
        opcode    = op;
        mem_ready = rdy;
        e.st  = st;
        e.c   = exp_ctrl(st, op, rdy);
        e.cnt = model_cnt;
        exp_q.push_back(e);
    endtask

    task automatic do_instr(logic [5:0] op, int fwait, int mwait, int rst_at);
        step_t s[$];
        bit    counted = 1'b1;
        for (int i = 0; i < fwait; i++) s.push_back('{1, 1'b0, 1'b0});
        s.push_back('{1, 1'b1, 1'b0});
        s.push_back('{2, 1'($urandom), 1'b1});
        if (op == 6'd0) begin
            s.push_back('{7, 1'($urandom), 1'b1});
            s.push_back('{8, 1'($urandom), 1'b1});
        end else if (op == 6'd35) begin
            s.push_back('{3, 1'($urandom), 1'b1});
            for (int i = 0; i < mwait; i++) s.push_back('{4, 1'b0, 1'b1});
            s.push_back('{4, 1'b1, 1'b1});
            s.push_back('{5, 1'($urandom), 1'b1});
        end else if (op == 6'd43) begin
            s.push_back('{3, 1'($urandom), 1'b1});
            for (int i = 0; i < mwait; i++) s.push_back('{6, 1'b0, 1'b1});
            s.push_back('{6, 1'b1, 1'b1});
        end else if (op == 6'd4) begin
            s.push_back('{9, 1'($urandom), 1'b1});
        end else if (JUMP_EN && op == 6'd2) begin
            s.push_back('{10, 1'($urandom), 1'b1});
        end else begin
            counted = 1'b0;
        end
        for (int i = 0; i < s.size(); i++) begin
            if (i == rst_at) begin
                drive(1'b0, s[i].useop ? op : 6'($urandom), s[i].rdy, s[i].st);
                model_cnt = 0;
                drive(1'b1, 6'($urandom), 1'($urandom), 0);
                return;
            end
            drive(1'b1, s[i].useop ? op : 6'($urandom), s[i].rdy, s[i].st);
        end
        if (counted) model_cnt++;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("state", int'(a_state), e.st);
            check("ctrl", int'({a_pcwrite, a_pcwritecond, a_iord, a_memread, a_memwrite,
                                a_irwrite, a_memtoreg, a_regdst, a_regwrite, a_alusrca,
                                a_alusrcb, a_aluop, a_pcsource, a_illegal}), int'(e.c));
            check("count16", int'(a_count), e.cnt % 65536);
            check("state_w2", int'(b_state), e.st);
            check("count2", int'(b_count), e.cnt % 4);
        end
    end

    initial begin : stim
        logic [5:0] op;
        repeat (2) @(posedge clk);
        drive(1'b1, 6'($urandom), 1'($urandom), 0);

        do_instr(6'b100011, 0, 0, -1);
        for (int i = 0; i < 3; i++) do_instr(6'b000000, 0, 0, -1);
        do_instr(6'b101011, 0, 2, -1);
        do_instr(6'b000000, 3, 0, -1);
        do_instr(6'b001000, 0, 0, -1);
        do_instr(6'b000010, 0, 0, -1);
        do_instr(6'b100011, 0, 3, 4);
        for (int i = 0; i < 5; i++) do_instr(6'b000100, 0, 0, -1);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 5))
                0: op = 6'b000000;
                1: op = 6'b100011;
                2: op = 6'b101011;
                3: op = 6'b000100;
                4: op = 6'b000010;
                default: op = 6'($urandom);
            endcase
            do_instr(op, $urandom_range(0, 2), $urandom_range(0, 3),
                     ($urandom_range(0, 19) == 0) ? $urandom_range(0, 6) : -1);
        end

        drive(1'b1, 6'($urandom), 1'b0, 1);
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencing controller for the MIPS datapath.
- Replaces single-cycle decode with a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback over 3-5 cycles.
- Drives shared memory, ALU, PC and register-file enables.
- Waits on a memory ready handshake.
- Counts retired instructions.

Parameters:
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- opcode  input  6  instruction[31:26] from the instruction register.
- mem_ready  input  1  memory completes current read/write this cycle.
- pcwrite  output  1  unconditional PC load.
- pcwritecond  output  1  PC load if ALU zero.
- iord  output  1  memory address select: 0=PC, 1=ALUOut.
- memread  output  1  memory read request.
- memwrite  output  1  memory write request.
- irwrite  output  1  instruction register load.
- memtoreg  output  1  writeback select: 1=MDR, 0=ALUOut.
- regdst  output  1  destination select: 1=rd, 0=rt.
- regwrite  output  1  register-file write.
- alusrca  output  1  ALU A select: 0=PC, 1=rs.
- alusrcb  output  2  ALU B select: 00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- aluop  output  2  00 add, 01 subtract, 10 funct-decoded.
- pcsource  output  2  00 ALU, 01 ALUOut, 10 jump target.
- illegal_op  output  1  unsupported opcode seen in DECODE.
- state_dbg  output  4  current state code.
- instr_count  output  CNT_W  retired instructions.

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10.
- Codes 11-15: all outputs 0, next state FETCH.
- Reset:
  - rst_n low at a clock edge forces IDLE and clears instr_count to 0, from any state including mid-instruction and mid-memory-wait.
  - In IDLE every control output is 0.
  - IDLE always goes to FETCH next cycle.
- Outputs are decoded from the state register. Every output not listed for a state is 0.
  - FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00. irwrite=pcwrite=mem_ready (only Mealy terms). Stay while mem_ready=0; go to DECODE when 1.
  - DECODE: alusrca=0, alusrcb=11, aluop=00.
    - Opcode 000000 -> EXEC; 100011 or 101011 -> MEMADR; 000100 -> BRANCH.
    - Any other opcode: illegal_op=1 for this cycle, next FETCH, no writes, not counted.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00. Next MEMRD if opcode=100011, else MEMWR.
  - MEMRD: memread=1, iord=1. Hold until mem_ready, then MEMWB.
  - MEMWB: regwrite=1, memtoreg=1, regdst=0. Next FETCH.
  - MEMWR: memwrite=1, iord=1. Hold until mem_ready, then FETCH.
  - EXEC: alusrca=1, alusrcb=00, aluop=10. Next ALUWB.
  - ALUWB: regwrite=1, regdst=1, memtoreg=0. Next FETCH.
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01. Next FETCH.
- mem_ready is ignored outside FETCH/MEMRD/MEMWR.
- Opcode is sampled every cycle; the datapath holds the IR stable after FETCH.
- Latency with mem_ready tied 1: R-type 4, lw 5, sw 4, beq 3 cycles. Each wait cycle adds 1.
- instr_count increments by 1 on the edge leaving MEMWB, ALUWB, BRANCH, JUMP, or MEMWR with mem_ready=1. Wraps modulo 2^CNT_W.

Optional Feature:
- MC_JUMP_EN defined: opcode 000010 in DECODE goes to JUMP. JUMP drives pcwrite=1, pcsource=10; next FETCH; counted; total 3 cycles.
- Undefined: 000010 is illegal; state 10 is treated as unused.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J;
  - 4-bit state codes;
  - ALUOP_ADD/SUB/FUNCT;
  - ALUSRCB_* and PCSRC_* encodings.
- No sub-module: one FSM with next-state logic, output decode and counter in one file.

Test Plan:
- Reset then lw, mem_ready=1: state_dbg 0,1,2,3,4,5,1. regwrite and memtoreg high only in cycle of state 5. instr_count 0->1.
- R-type with mem_ready=1: states 1,2,7,8. aluop=10 in EXEC; regwrite=1, regdst=1 in ALUWB. Repeated 3 times -> instr_count=3.
- sw with mem_ready low 2 cycles in MEMWR: memwrite=1, iord=1 held 3 cycles. FETCH follows. Count increments once.
- FETCH with mem_ready=0 for 3 cycles: irwrite=pcwrite=0, memread=1 throughout. Then mem_ready=1 -> irwrite=pcwrite=1 for exactly 1 cycle.
- Opcode 001000 in DECODE: illegal_op=1 for one cycle, then FETCH, count unchanged. Opcode 000010: illegal without MC_JUMP_EN; with it, JUMP with pcsource=10, pcwrite=1.
- rst_n low for 1 cycle during MEMRD wait: next state IDLE with all outputs 0, instr_count=0, then FETCH. CNT_W=2 with 5 beqs -> instr_count=1 (wrap).
